operand_serializer: RTL and testbench
=====================================

OPERAND_SERIALIZER -- requirements
Module: operand_serializer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, meaning the serial word width in bits, taken from the shared package.
REQ-002 SHALL have parameter NUM_WORDS, default 32, meaning the number of words per operand (256/WORD_SIZE).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the offered pair this cycle.
REQ-007 SHALL have ports op_a and op_b, input, WORD_SIZE*NUM_WORDS bits each: wide operands.
REQ-008 SHALL have port valid_out, output, 1 bit: a serial word pair is present.
REQ-009 SHALL have port last_out, output, 1 bit: the present word pair is the final one of an operation.
REQ-010 SHALL have ports data_out_0 and data_out_1, output, wordType each: the current words of op_a and op_b.
REQ-011 SHALL have port busy, output, 1 bit: the FSM is in SEND.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and SEND, plus a word counter of $clog2(NUM_WORDS) bits.
REQ-013 SHALL drive in_ready high in IDLE, and in SEND only when the counter equals NUM_WORDS-1; low otherwise.
REQ-014 SHALL treat acceptance as in_valid and in_ready both high at a rising edge: load op_a/op_b into shift registers, clear the counter, enter SEND.
REQ-015 SHALL assert valid_out in every SEND cycle, so the first word appears the cycle after acceptance and latency is 1 cycle.
REQ-016 SHALL emit words LSB-first: word k = bits [k*WORD_SIZE +: WORD_SIZE], with k = 0..NUM_WORDS-1 on consecutive cycles and no gaps.
REQ-017 SHALL drive data_out_0/1 directly from the low word of each shift register; each SEND edge shifts right by WORD_SIZE and increments the counter.
REQ-018 SHALL assert last_out exactly when in SEND with counter == NUM_WORDS-1.
REQ-019 SHALL handle the last-word edge as follows: with acceptance, reload, clear the counter and stay in SEND (back-to-back, valid_out stays high); without acceptance, return to IDLE.
REQ-020 SHALL drive data_out_0/1 to 0 when valid_out is low.
REQ-021 SHALL ignore changes on op_a/op_b outside the acceptance edge.

Reset
REQ-022 SHALL, while rst is low and regardless of clk, force state IDLE, counter 0, shift registers 0, valid_out 0, last_out 0, busy 0 and data_out_0/1 0.
REQ-023 SHALL discard any in-progress operation on reset mid-SEND (no last_out emitted); after release, in_ready is 1 and the next accepted pair starts at word 0.

Configuration
REQ-024 SHALL, with macro SER_ABORT_EN defined, add port abort, input, 1 bit.
REQ-025 SHALL, under SER_ABORT_EN, treat abort high in a SEND cycle as follows: last_out is forced high combinationally for the current word, in_ready is low, and the next edge returns to IDLE.
REQ-026 SHALL, under SER_ABORT_EN, ignore abort in IDLE.
REQ-027 SHALL, without SER_ABORT_EN, have no abort port and behave per REQ-012..023 only.

Structure
REQ-028 SHALL take wordSize/WORD_SIZE, wordType and NUM_WORDS from the shared word-serial package, which is also used by the word-serial adder.
REQ-029 SHALL place the FSM state enum (IDLE, SEND) in that package.
REQ-030 SHALL be a single module; a sub-module is unnecessary because the two shift registers are inline.

Verification
REQ-031 SHALL pass single op: op_a=1, op_b=2^256-1 -> word0 = 0x01/0xFF, words 1..31 = 0x00/0xFF, last_out on the 32nd valid cycle only.
REQ-032 SHALL pass back-to-back: in_valid held, two pairs -> 64 consecutive valid_out cycles, last_out at cycles 32 and 64, in_ready high only in IDLE and at cycles 32 and 64.
REQ-033 SHALL pass chain-to-adder: serializer driving the word-serial adder with a=b=0x80..80 -> reassembled sum equals (a+b) mod 2^256, and the adder carry is clear for the next op.
REQ-034 SHALL pass reset mid-SEND: rst low at word 10 -> all outputs 0 immediately; after release, a new op starts at word 0 with no stale words.
REQ-035 SHALL pass abort (SER_ABORT_EN): abort at word 5 -> word 5 carries last_out=1, valid_out low the next cycle, in_ready high.
REQ-036 SHALL pass in_valid with in_ready low: op_a changed mid-SEND -> the emitted stream is unaffected.

Source files
------------

// File: rtl/operand_serializer_pkg.sv
// Shared word-serial package: word geometry, the word type and the
// serializer FSM state encoding. The word-serial adder uses the same package.
package operand_serializer_pkg;

  localparam int WORD_SIZE    = 8;
  localparam int OPERAND_BITS = 256;
  localparam int NUM_WORDS    = OPERAND_BITS / WORD_SIZE;

  typedef logic [WORD_SIZE-1:0] word_type;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/operand_serializer.sv
// operand_serializer: accepts a pair of wide operands and streams them out
// LSB-word first, one word pair per cycle, with back-to-back chaining on the
// last word.
// Optional macro SER_ABORT_EN adds an 'abort' input that ends the current
// operation early (last_out forced high on the current word).
module operand_serializer
  import operand_serializer_pkg::*;
#(
  parameter int WORD_SIZE = operand_serializer_pkg::WORD_SIZE,
  parameter int NUM_WORDS = operand_serializer_pkg::NUM_WORDS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WORD_SIZE*NUM_WORDS-1:0] op_a,
  input  logic [WORD_SIZE*NUM_WORDS-1:0] op_b,
`ifdef SER_ABORT_EN
  input  logic                           abort,
`endif
  output logic                           valid_out,
  output logic                           last_out,
  output logic [WORD_SIZE-1:0]           data_out_0,
  output logic [WORD_SIZE-1:0]           data_out_1,
  output logic                           busy
);

  localparam int OP_W  = WORD_SIZE * NUM_WORDS;
  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  ser_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   sh_a_q, sh_a_d;
  logic [OP_W-1:0]   sh_b_q, sh_b_d;

  logic in_send;
  logic at_last;
  logic abort_now;
  logic accept;

  // Handshake and output decode from the current state; abort only matters in SEND.
  always_comb begin
    in_send   = (state_q == SEND);
    abort_now = 1'b0;
`ifdef SER_ABORT_EN
    abort_now = in_send && abort;
`endif
    at_last    = in_send && (cnt_q == LAST_CNT);
    in_ready   = ((state_q == IDLE) || at_last) && !abort_now;
    accept     = in_valid && in_ready;
    valid_out  = in_send;
    busy       = in_send;
    last_out   = at_last || abort_now;
    data_out_0 = in_send ? sh_a_q[WORD_SIZE-1:0] : '0;
    data_out_1 = in_send ? sh_b_q[WORD_SIZE-1:0] : '0;
  end

  // Next-state: load on acceptance, otherwise shift one word per SEND cycle
  // and drop back to IDLE after the final (or aborted) word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    if (accept) begin
      state_d = SEND;
      cnt_d   = '0;
      sh_a_d  = op_a;
      sh_b_d  = op_b;
    end else if (in_send) begin
      if (at_last || abort_now) begin
        state_d = IDLE;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        sh_a_d = sh_a_q >> WORD_SIZE;
        sh_b_d = sh_b_q >> WORD_SIZE;
      end
    end
  end

  // State, counter and shift registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
    end
  end

endmodule

// File: tb/tb_operand_serializer.sv
// Testbench for operand_serializer. A stream-level reference model keeps a
// queue of the word pairs still owed by the block; each accepted operand pair
// appends NUM_WORDS entries. Define SER_ABORT_EN to also exercise abort.
module tb_operand_serializer;
  import operand_serializer_pkg::*;

  localparam int W   = WORD_SIZE;
  localparam int N   = NUM_WORDS;
  localparam int OPW = W * N;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           abort = 1'b0;
  logic [OPW-1:0] op_a = '0;
  logic [OPW-1:0] op_b = '0;
  logic           in_ready, valid_out, last_out, busy;
  logic [W-1:0]   d0, d1;

  always #5 clk = ~clk;

  operand_serializer #(.WORD_SIZE(W), .NUM_WORDS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
`ifdef SER_ABORT_EN
    .abort      (abort),
`endif
    .valid_out  (valid_out),
    .last_out   (last_out),
    .data_out_0 (d0),
    .data_out_1 (d1),
    .busy       (busy)
  );

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         last;
  } beat_t;

  beat_t exp_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  // word-serial adder fed from the serializer outputs
  logic [OPW-1:0] sum_acc  = '0;
  logic [OPW-1:0] sum_done = '0;
  logic           carry    = 1'b0;
  int             widx     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OPW-1:0] rand256();
    logic [OPW-1:0] r;
    for (int i = 0; i < OPW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Compare DUT outputs with the model's current expectation, then feed the adder.
  task automatic check_outputs();
    logic  e_valid, e_abort, e_last, e_ready;
    beat_t f;
    logic [W:0] s;
    if (!rst) begin
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_last",  32'(last_out),  32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_d0",    32'(d0),        32'd0);
      chk("rst_d1",    32'(d1),        32'd0);
      widx  = 0;
      carry = 1'b0;
      return;
    end
    e_valid = (exp_q.size() > 0);
    e_abort = abort && e_valid;
    e_last  = (exp_q.size() == 1) || e_abort;
    e_ready = (exp_q.size() <= 1) && !e_abort;
    f       = e_valid ? exp_q[0] : '0;
    chk("valid_out",  32'(valid_out), 32'(e_valid));
    chk("busy",       32'(busy),      32'(e_valid));
    chk("last_out",   32'(last_out),  32'(e_last));
    chk("in_ready",   32'(in_ready),  32'(e_ready));
    chk("data_out_0", 32'(d0),        32'(f.a));
    chk("data_out_1", 32'(d1),        32'(f.b));
    if (valid_out && widx < N) begin
      s = {1'b0, d0} + {1'b0, d1} + {{W{1'b0}}, carry};
      sum_acc[widx*W +: W] = s[W-1:0];
      carry = s[W];
      widx++;
      if (last_out) begin
        sum_done = sum_acc;
        widx     = 0;
        carry    = 1'b0;
      end
    end
  endtask

  // Advance the model across one rising edge using the inputs being driven.
  task automatic update_model();
    logic ab, acc;
    if (!rst) begin
      exp_q.delete();
      return;
    end
    ab  = abort && (exp_q.size() > 0);
    acc = in_valid && (exp_q.size() <= 1) && !ab;
    if (ab) exp_q.delete();
    else if (exp_q.size() > 0) exp_q.delete(0);
    if (acc)
      for (int k = 0; k < N; k++)
        exp_q.push_back('{a: op_a[k*W +: W], b: op_b[k*W +: W], last: (k == N - 1)});
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic run(input int n, input bit churn);
    for (int i = 0; i < n; i++) begin
      if (churn) begin
        op_a = rand256();
        op_b = rand256();
      end
      cycle();
    end
  endtask

  task automatic send(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  logic [OPW-1:0] ca, cb;

  initial begin
    // reset held across edges, then released
    rst = 1'b0;
    run(2, 1'b0);
    rst = 1'b1;
    run(1, 1'b0);

    // single op: 1 and all-ones
    send(OPW'(1), '1);
    run(33, 1'b0);

    // back-to-back with in_valid held: two pairs, 64 contiguous words
    op_a     = rand256();
    op_b     = rand256();
    in_valid = 1'b1;
    cycle();
    op_a = rand256();
    op_b = rand256();
    run(32, 1'b0);
    in_valid = 1'b0;
    run(33, 1'b1);

    // chain to word-serial adder: 0x80..80 + 0x80..80
    ca       = {(OPW/8){8'h80}};
    cb       = {(OPW/8){8'h80}};
    sum_done = '0;
    send(ca, cb);
    run(33, 1'b0);
    n_assert++;
    assert (sum_done === ca + cb) else begin
      n_fail++;
      $error("FAIL adder_sum: observed %h expected %h", sum_done, ca + cb);
    end
    chk("adder_carry_clear", 32'(carry), 32'd0);

    // reset mid-SEND at word 10
    send(rand256(), rand256());
    run(10, 1'b0);
    rst = 1'b0;
    #1;
    check_outputs();
    exp_q.delete();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b1;
    run(1, 1'b0);
    send(rand256(), rand256());
    run(33, 1'b0);

    // operands change while in_ready is low
    send(rand256(), rand256());
    run(34, 1'b1);

`ifdef SER_ABORT_EN
    // abort at word 5, then abort ignored in IDLE
    send(rand256(), rand256());
    run(5, 1'b0);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    run(2, 1'b0);
    abort = 1'b1;
    run(2, 1'b0);
    abort = 1'b0;
`endif

    // random traffic
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 45; c++) begin
        in_valid = 1'($urandom_range(0, 1));
        op_a     = rand256();
        op_b     = rand256();
        cycle();
      end
    end
    in_valid = 1'b0;
    run(34, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
